// File: rtl/ifu_prefetch.sv
// ifu_prefetch: AXI-lite sequential instruction prefetcher with a DEPTH-entry FIFO and redirect flush.
// Optional feature macro IFU_FAULT_EN: per-entry out_fault flag; fetch halts after a faulting response.
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_ins,
`ifdef IFU_FAULT_EN
    output logic            out_fault,
`endif
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [XLEN-1:0] fetch_pc, resp_pc, pend_addr, target_pc;
    logic [CW-1:0]   wr_ptr, rd_ptr, count, inflight, inflight_nxt, drop_cnt;
    logic            pend, stale, halt, credit, ar_hs, r_hs, push, pop, unused_bits;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    // An AR left waiting by the slave is replayed from pend_addr so it stays stable across redirects.
    always_comb begin
        count        = wr_ptr - rd_ptr;
        credit       = ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(DEPTH);
        arvalid      = !rst && (pend || (credit && !halt));
        araddr       = pend ? pend_addr : fetch_pc;
        rready       = !rst;
        ar_hs        = arvalid && arready;
        r_hs         = rvalid && rready;
        push         = r_hs && drop_cnt == '0 && !redirect_valid;
        pop          = out_valid && out_ready && !redirect_valid;
        out_valid    = wr_ptr != rd_ptr;
        out_pc       = pc_mem[rd_ptr[AW-1:0]];
        out_ins      = ins_mem[rd_ptr[AW-1:0]];
        inflight_nxt = inflight + CW'(ar_hs) - CW'(r_hs);
        target_pc    = {redirect_pc[XLEN-1:2], 2'b00};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            pend_addr <= RESET_PC;
            pend      <= 1'b0;
            stale     <= 1'b0;
            inflight  <= '0;
            drop_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            inflight  <= inflight_nxt;
            pend      <= arvalid && !arready;
            pend_addr <= araddr;
            stale     <= arvalid && !arready && (stale || redirect_valid);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                drop_cnt <= inflight_nxt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (ar_hs && !stale)
                    fetch_pc <= fetch_pc + XLEN'(4);
                drop_cnt <= drop_cnt + CW'(ar_hs && stale) - CW'(r_hs && drop_cnt != '0);
                if (push) begin
                    wr_ptr  <= wr_ptr + CW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr[AW-1:0]]  <= resp_pc;
            ins_mem[wr_ptr[AW-1:0]] <= rdata;
        end
    end
`ifdef IFU_FAULT_EN
    logic fault_mem [DEPTH];
    always_comb begin
        out_fault   = fault_mem[rd_ptr[AW-1:0]];
        unused_bits = ^redirect_pc[1:0];
    end
    always_ff @(posedge clk) begin
        if (push)
            fault_mem[wr_ptr[AW-1:0]] <= rresp != 2'b00;
    end
    always_ff @(posedge clk) begin
        if (rst || redirect_valid)
            halt <= 1'b0;
        else if (push && rresp != 2'b00)
            halt <= 1'b1;
    end
`else
    always_comb begin
        halt        = 1'b0;
        unused_bits = ^{rresp, redirect_pc[1:0]};
    end
`endif
endmodule
